// File: rtl/robo_pkg.sv
// rtl/robo_pkg.sv - shared state encodings, defaults and direction codes for the wall follower
package robo_pkg;

    typedef enum logic [2:0] {
        SEEK       = 3'd0,
        FOLLOW     = 3'd1,
        AFTER_LEFT = 3'd2,
        TURN_R2    = 3'd3,
        TURN_R1    = 3'd4,
        CLEAN      = 3'd5,
        STUCK      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DIR_NORTH = 2'b00,
        DIR_SOUTH = 2'b01,
        DIR_EAST  = 2'b10,
        DIR_WEST  = 2'b11
    } dir_t;

    localparam int REMOVE_CYCLES_DEF = 3;
    localparam int STUCK_TURNS_DEF   = 12;
    // Wide enough for REMOVE_CYCLES up to 15.
    localparam int TIMER_W           = 4;

endpackage

// File: rtl/remove_timer.sv
// rtl/remove_timer.sv - barrier-clearing cycle counter with completion flag
module remove_timer
    import robo_pkg::*;
#(
    parameter int REMOVE_CYCLES = REMOVE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic done
);

    logic [TIMER_W-1:0] count;

    // Load counts the remove that started the clean; each further remove bumps it.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= TIMER_W'(1);
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // High when the remove happening this cycle brings the count to REMOVE_CYCLES.
    assign done = ({1'b0, count} + (TIMER_W + 1)'(1)) >= (TIMER_W + 1)'(REMOVE_CYCLES);

endmodule

// File: rtl/robo_wall_follower.sv
// rtl/robo_wall_follower.sv - left-hand wall follower with barrier clearing and enclosure detection
module robo_wall_follower
    import robo_pkg::*;
#(
    parameter int REMOVE_CYCLES = REMOVE_CYCLES_DEF,
    parameter int STUCK_TURNS   = STUCK_TURNS_DEF,
    parameter int MOVE_W        = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              head,
    input  logic              left,
    input  logic              under,
    input  logic              barrier,
    output logic              front,
    output logic              turn,
    output logic              remove,
    output logic              stuck,
    output logic [MOVE_W-1:0] moves
);

    localparam int TC_W = $clog2(STUCK_TURNS + 1);

    state_t          state, state_nx, saved, saved_nx;
    logic [TC_W-1:0] turn_cnt;
    logic            act_front, act_turn, act_remove;
    logic            tmr_load, tmr_inc, tmr_done;

    remove_timer #(.REMOVE_CYCLES(REMOVE_CYCLES)) u_remove_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .inc   (tmr_inc),
        .done  (tmr_done)
    );

    // Action selection and next state from the registered state and live sensors.
    always_comb begin
        act_front  = 1'b0;
        act_turn   = 1'b0;
        act_remove = 1'b0;
        tmr_load   = 1'b0;
        tmr_inc    = 1'b0;
        state_nx   = state;
        saved_nx   = saved;
        case (state)
            SEEK, FOLLOW, AFTER_LEFT: begin
                if (under) begin
                    act_remove = 1'b1;
                end else if (barrier) begin
                    act_remove = 1'b1;
                    if (REMOVE_CYCLES > 1) begin
                        state_nx = CLEAN;
                        saved_nx = state;
                        tmr_load = 1'b1;
                    end
                end else if (state == FOLLOW && !left) begin
                    act_turn = 1'b1;
                    state_nx = AFTER_LEFT;
                end else if (!head) begin
                    act_front = 1'b1;
                    state_nx  = (state == SEEK && !left) ? SEEK : FOLLOW;
                end else begin
                    act_turn = 1'b1;
                    state_nx = TURN_R2;
                end
            end
            TURN_R2: begin
                act_turn = 1'b1;
                state_nx = TURN_R1;
            end
            TURN_R1: begin
                act_turn = 1'b1;
                state_nx = FOLLOW;
            end
            CLEAN: begin
                if (!barrier) begin
                    state_nx = saved;
                end else begin
                    act_remove = 1'b1;
                    tmr_inc    = 1'b1;
                    if (tmr_done) begin
                        state_nx = saved;
                    end
                end
            end
            default: begin
                state_nx = STUCK;
            end
        endcase
        // The turn that completes the run of STUCK_TURNS overrides any other destination.
        if (act_turn && turn_cnt == TC_W'(STUCK_TURNS - 1)) begin
            state_nx = STUCK;
        end
    end

    // Reset must silence the actuators at once, not at the next edge.
    assign front  = act_front  & ~reset;
    assign turn   = act_turn   & ~reset;
    assign remove = act_remove & ~reset;
    assign stuck  = (state == STUCK);

    // State, saved return state, consecutive-turn run length and saturating move count.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state    <= SEEK;
            saved    <= SEEK;
            turn_cnt <= '0;
            moves    <= '0;
        end else begin
            state <= state_nx;
            saved <= saved_nx;
            if (act_front || act_remove) begin
                turn_cnt <= '0;
            end else if (act_turn) begin
                turn_cnt <= turn_cnt + 1'b1;
            end
            if (act_front && moves != '1) begin
                moves <= moves + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_robo_wall_follower.sv
// tb/tb_robo_wall_follower.sv - scoreboard bench for robo_wall_follower
module tb_robo_wall_follower;

    localparam int RC = 3;
    localparam int ST = 12;
    localparam int MW = 9;

    logic          clock = 1'b0;
    logic          reset, head, left, under, barrier;
    logic          front, turn, remove, stuck;
    logic [MW-1:0] moves;

    robo_wall_follower #(
        .REMOVE_CYCLES (RC),
        .STUCK_TURNS   (ST),
        .MOVE_W        (MW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .head    (head),
        .left    (left),
        .under   (under),
        .barrier (barrier),
        .front   (front),
        .turn    (turn),
        .remove  (remove),
        .stuck   (stuck),
        .moves   (moves)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          f;
        logic          t;
        logic          r;
        logic          s;
        logic [MW-1:0] mv;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference robot: mode 0 = looking for a wall, 1 = hugging it, 2 = just went round a corner.
    // Multi-cycle manoeuvres are tracked as "work still owed" counters.
    int m_mode, m_pend, m_clean, m_row, m_moves;
    bit m_stuck;

    function automatic void model_reset();
        m_mode  = 0;
        m_pend  = 0;
        m_clean = 0;
        m_row   = 0;
        m_moves = 0;
        m_stuck = 1'b0;
    endfunction

    function automatic void model_act(input bit rst, input bit h, input bit l, input bit u,
                                      input bit b, output bit f, output bit t, output bit r);
        f = 1'b0;
        t = 1'b0;
        r = 1'b0;
        if (rst || m_stuck)        begin end
        else if (m_pend > 0)       t = 1'b1;
        else if (m_clean > 0)      r = b;
        else if (u || b)           r = 1'b1;
        else if (m_mode == 1 && !l) t = 1'b1;
        else if (!h)               f = 1'b1;
        else                       t = 1'b1;
    endfunction

    function automatic void model_step(input bit h, input bit l, input bit u, input bit b,
                                       input bit f, input bit t, input bit r);
        if (m_stuck) return;
        if (m_pend > 0)              m_pend--;
        else if (m_clean > 0)        m_clean = b ? m_clean - 1 : 0;
        else if (u)                  begin end
        else if (b)                  m_clean = RC - 1;
        else if (m_mode == 1 && !l)  m_mode = 2;
        else if (!h)                 m_mode = (m_mode == 0 && !l) ? 0 : 1;
        else begin
            m_pend = 2;
            m_mode = 1;
        end
        if (f || r)      m_row = 0;
        else if (t)      m_row++;
        if (m_row >= ST) m_stuck = 1'b1;
        if (f && m_moves < (1 << MW) - 1) m_moves++;
    endfunction

    // One clock: drive sensors just after the rising edge, predict, let the falling edge commit.
    task automatic cycle(input bit rst, input bit h, input bit l, input bit u, input bit b);
        bit   f, t, r;
        exp_t e;
        @(posedge clock);
        #1;
        reset   = rst;
        head    = h;
        left    = l;
        under   = u;
        barrier = b;
        if (rst) model_reset();
        model_act(rst, h, l, u, b, f, t, r);
        e.f  = f;
        e.t  = t;
        e.r  = r;
        e.s  = m_stuck;
        e.mv = MW'(m_moves);
        sb.push_back(e);
        @(negedge clock);
        #1;
        if (!rst) model_step(h, l, u, b, f, t, r);
    endtask

    // Monitor: sample just before the committing edge and compare against the oldest prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({front, turn, remove, stuck, moves} !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: dut f/t/r/s=%b%b%b%b moves=%0d, expected f/t/r/s=%b%b%b%b moves=%0d",
                             $time, front, turn, remove, stuck, moves, e.f, e.t, e.r, e.s, e.mv);
                end
                checks++;
                if ($countones({front, turn, remove}) > 1) begin
                    errors++;
                    $display("FAIL exclusive_actions @%0t: f/t/r=%b%b%b, expected at most one set",
                             $time, front, turn, remove);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        head    = 1'b0;
        left    = 1'b0;
        under   = 1'b0;
        barrier = 1'b0;
        model_reset();

        cycle(1, 0, 1, 0, 0);
        cycle(1, 1, 1, 1, 1);
        // Open corridor along a wall.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
        // Corner ahead: right turn as three lefts, then advance.
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // Barrier held for the full clean, then advance.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);
        // Trash outranks a missing left wall.
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // Barrier vanishing mid-clean.
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        // Enclosed cell, then recover with reset.
        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < ST + 3; i++) cycle(0, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Reset part-way through a clean; first actions afterwards come from SEEK.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Random wandering with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        // Long corridor to saturate the move counter.
        cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < (1 << MW) + 10; i++) cycle(0, 0, 1, 0, 0);

        @(posedge clock);
        @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d predictions left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
